// File: rtl/async_rst_sync_recover_block.sv
// Purpose : conditions a reset request into a glitch-stretched, clean reset on clk_50m.
// Latency : rst rises SYNC_STAGES edges after rst_in is sampled high; it falls after
//           RELEASE_CYCLES consecutive low samples of the synchronised request.
// Backpressure: none; free-running, every edge updates state.
//
// Ports
//   clk_50m    : sole clock, all state updates on its rising edge
//   rst_in     : reset request, synchronous, active-high
//   rst        : registered conditioned reset, active-high
//   rst_n      : registered complement of rst
//   rst_done   : one-cycle pulse in the cycle after rst falls
//   rst_events : saturating count of rst rising transitions
module async_rst_sync_recover_block #(
    parameter int SYNC_STAGES    = 2,   // legal 2..4
    parameter int RELEASE_CYCLES = 8    // legal 1..255
) (
    input  logic       clk_50m,
    input  logic       rst_in,
    output logic       rst,
    output logic       rst_n,
    output logic       rst_done,
    output logic [7:0] rst_events
);

    localparam logic [7:0] REL_CNT  = 8'(RELEASE_CYCLES);
    localparam logic [7:0] REL_LAST = 8'(RELEASE_CYCLES - 1);

    // Power-up values: the chain starts full of ones so the block comes up in
    // reset and releases on its own once the request has been seen low long enough.
    logic [SYNC_STAGES-1:0] sync_q       = '1;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   rst_q        = 1'b1;
    logic                   rst_d;
    logic                   rst_n_q      = 1'b0;
    logic                   rst_n_d;
    logic [7:0]             low_cnt_q    = 8'd0;
    logic [7:0]             low_cnt_d;
    logic                   rst_done_q   = 1'b0;
    logic                   rst_done_d;
    logic [7:0]             rst_events_q = 8'd0;
    logic [7:0]             rst_events_d;

    logic                   rst_sync;

    assign rst_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], rst_in};
        rst_d        = rst_q;
        low_cnt_d    = low_cnt_q;

        if (rst_sync) begin
            // A high sample always wins, including on the edge where the
            // release count would otherwise have completed.
            rst_d     = 1'b1;
            low_cnt_d = 8'd0;
        end else if (rst_q) begin
            if (low_cnt_q >= REL_LAST) begin
                // This edge takes the RELEASE_CYCLES-th consecutive low sample.
                rst_d     = 1'b0;
                low_cnt_d = REL_CNT;
            end else begin
                low_cnt_d = low_cnt_q + 8'd1;
            end
        end

        rst_n_d      = ~rst_d;
        rst_done_d   = rst_q & ~rst_d;

        rst_events_d = rst_events_q;
        if (!rst_q && rst_d && (rst_events_q != 8'hFF)) begin
            rst_events_d = rst_events_q + 8'd1;
        end
    end

    // rst_in reaches this block only through the synchroniser chain; the
    // chain and the event counter are never cleared by it.
    always_ff @(posedge clk_50m) begin
        sync_q       <= sync_d;
        rst_q        <= rst_d;
        rst_n_q      <= rst_n_d;
        low_cnt_q    <= low_cnt_d;
        rst_done_q   <= rst_done_d;
        rst_events_q <= rst_events_d;
    end

    assign rst        = rst_q;
    assign rst_n      = rst_n_q;
    assign rst_done   = rst_done_q;
    assign rst_events = rst_events_q;

endmodule

// File: tb/tb_async_rst_sync_recover_block.sv
// Purpose : self-checking bench for async_rst_sync_recover_block (default parameters).
// Latency : outputs compared on the falling edge after each rising edge.
// Backpressure: n/a; stimulus is one rst_in value per clock.
module tb_async_rst_sync_recover_block;

    localparam int N = 2;
    localparam int R = 8;

    logic       clk_50m = 1'b0;
    logic       rst_in  = 1'b0;
    logic       rst;
    logic       rst_n;
    logic       rst_done;
    logic [7:0] rst_events;

    int n_vec = 0;
    int n_err = 0;

    async_rst_sync_recover_block #(
        .SYNC_STAGES   (N),
        .RELEASE_CYCLES(R)
    ) dut (
        .clk_50m   (clk_50m),
        .rst_in    (rst_in),
        .rst       (rst),
        .rst_n     (rst_n),
        .rst_done  (rst_done),
        .rst_events(rst_events)
    );

    always #10 clk_50m = ~clk_50m;

    // Reference model: rst_in delayed by N edges gives the synchronised request;
    // rst is set by any high sample and cleared once the run of consecutive low
    // samples reaches R.
    bit pipe[$];
    int lowrun  = 0;
    bit m_rst   = 1'b1;
    bit m_done  = 1'b0;
    int m_ev    = 0;

    function automatic void model_step(input bit v);
        bit s;
        bit nxt;
        s = pipe[$];
        void'(pipe.pop_back());
        pipe.push_front(v);
        lowrun = s ? 0 : lowrun + 1;
        if (s)                       nxt = 1'b1;
        else if (m_rst && lowrun >= R) nxt = 1'b0;
        else                         nxt = m_rst;
        m_done = m_rst && !nxt;
        if (!m_rst && nxt && m_ev < 255) m_ev++;
        m_rst = nxt;
    endfunction

    function automatic void chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endfunction

    task automatic cyc(input bit v);
        rst_in = v;
        @(posedge clk_50m);
        model_step(v);
        @(negedge clk_50m);
        chk("model_rst",    {7'd0, rst},      {7'd0, m_rst});
        chk("model_rst_n",  {7'd0, rst_n},    {7'd0, ~m_rst});
        chk("model_done",   {7'd0, rst_done}, {7'd0, m_done});
        chk("model_events", rst_events,       8'(m_ev));
    endtask

    typedef struct {
        bit         din;
        bit         exp_rst;
        bit         exp_done;
        logic [7:0] exp_ev;
    } vec_t;

    vec_t tbl[$];

    initial begin : main
        vec_t       v;
        logic [7:0] ev0;
        int         rel_idx;
        bit         lvl;
        int         len;

        for (int i = 0; i < N; i++) pipe.push_back(1'b1);

        // Power-up table: rst_in low from the first edge (edge index 0).
        for (int i = 0; i < 12; i++) begin
            v.din      = 1'b0;
            v.exp_rst  = (i < N + R - 1);
            v.exp_done = (i == N + R - 1);
            v.exp_ev   = 8'd0;
            tbl.push_back(v);
        end

        #1;
        chk("por_rst",    {7'd0, rst},      8'd1);
        chk("por_rst_n",  {7'd0, rst_n},    8'd0);
        chk("por_done",   {7'd0, rst_done}, 8'd0);
        chk("por_events", rst_events,       8'd0);

        foreach (tbl[i]) begin
            cyc(tbl[i].din);
            chk("tbl_rst",    {7'd0, rst},      {7'd0, tbl[i].exp_rst});
            chk("tbl_done",   {7'd0, rst_done}, {7'd0, tbl[i].exp_done});
            chk("tbl_events", rst_events,       tbl[i].exp_ev);
        end

        // Held high 11 cycles, then low: release 9 edges after the first low sample.
        for (int i = 0; i < 11; i++) cyc(1'b1);
        ev0 = rst_events;
        chk("held_ev_once", rst_events, 8'd1);
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0);
            chk("held_rst",  {7'd0, rst},      {7'd0, (i < N + R - 1)});
            chk("held_done", {7'd0, rst_done}, {7'd0, (i == N + R - 1)});
        end

        // Single-cycle pulse: asserts after 2 edges, stays high R cycles.
        ev0 = rst_events;
        cyc(1'b1);
        chk("pulse_rst_k", {7'd0, rst}, 8'd0);
        for (int i = 1; i < 14; i++) begin
            cyc(1'b0);
            chk("pulse_rst", {7'd0, rst}, {7'd0, (i >= N && i < 1 + N + R - 1)});
        end
        chk("pulse_ev", rst_events, ev0 + 8'd1);

        // Restart during release count: 5 low samples taken, then a 1-cycle high.
        for (int i = 0; i < 4; i++) cyc(1'b1);
        ev0 = rst_events;
        rel_idx = 6 + N + R - 1;
        for (int i = 0; i < 20; i++) begin
            cyc(i == 5);
            chk("restart_rst", {7'd0, rst}, {7'd0, (i < rel_idx)});
            chk("restart_ev",  rst_events,  ev0);
        end

        // Alternating windows 12/12, 13/13, 14/14, 15/15.
        ev0 = rst_events;
        for (int w = 12; w < 16; w++) begin
            for (int i = 0; i < w; i++) cyc(1'b1);
            for (int i = 0; i < w; i++) cyc(1'b0);
        end
        chk("windows_ev", rst_events, ev0 + 8'd4);

        // Randomised runs of random length against the model.
        for (int r = 0; r < 60; r++) begin
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 14);
            for (int i = 0; i < len; i++) cyc(lvl);
        end
        for (int i = 0; i < 12; i++) cyc(1'b0);

        // 300 pulses separated by 20 low cycles: counter saturates and holds.
        for (int p = 0; p < 300; p++) begin
            cyc(1'b1);
            for (int i = 0; i < 20; i++) cyc(1'b0);
        end
        chk("sat_events", rst_events, 8'd255);
        cyc(1'b1);
        for (int i = 0; i < 12; i++) cyc(1'b0);
        chk("sat_hold", rst_events, 8'd255);
        chk("sat_rst_low", {7'd0, rst}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/async_rst_sync_recover_block.md
ASYNC_RST_SYNC_RECOVER_BLOCK -- requirements
Module: async_rst_sync_recover

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on rst_in (legal 2..4).
REQ-002 Parameter RELEASE_CYCLES, default 8, consecutive low synchronized samples required before rst deasserts (legal 1..255).
REQ-003 Port clk_50m  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst_in  input  1  block reset request; one clock; reset is synchronous and active-high.
REQ-005 Port rst  output  1  registered conditioned reset, active-high, for downstream logic.
REQ-006 Port rst_n  output  1  registered complement of rst, always equal to ~rst.
REQ-007 Port rst_done  output  1  one-cycle pulse marking the cycle after rst falls.
REQ-008 Port rst_events  output  8  saturating count of rst rising transitions.

Function
REQ-009 rst_in SHALL be sampled into a SYNC_STAGES-deep shift chain s[0..SYNC_STAGES-1]; rst_sync = s[SYNC_STAGES-1].
REQ-010 Assertion: rst_in first sampled high at edge k -> rst = 1 after edge k+SYNC_STAGES; no filtering, a single-cycle high on rst_in SHALL assert rst.
REQ-011 low_cnt (8 bit) SHALL clear on every edge sampling rst_sync = 1 and increment (saturating at RELEASE_CYCLES) on every edge sampling rst_sync = 0 while rst = 1.
REQ-012 rst SHALL clear at the edge taking the RELEASE_CYCLES-th consecutive low sample of rst_sync; first low sample of rst_in at edge k -> rst = 0 after edge k+SYNC_STAGES+RELEASE_CYCLES-1.
REQ-013 Any high sample of rst_sync during the release count SHALL restart the count; rst SHALL stay 1 throughout.
REQ-014 Once rst = 0 it SHALL stay 0 until rst_sync is sampled high; rst_sync = 0 with rst = 0 leaves low_cnt unchanged.
REQ-015 Minimum rst high width SHALL therefore be RELEASE_CYCLES cycles for any rst_in pulse.
REQ-016 rst_done SHALL be 1 for exactly the one cycle immediately following the edge on which rst went 1->0, otherwise 0.
REQ-017 rst_events SHALL increment by 1 on each edge where rst goes 0->1, saturating at 255 with no wrap.
REQ-018 Simultaneous: if rst_sync is sampled high on the same edge the release count would complete, rst SHALL remain 1 and low_cnt clears.

Reset
REQ-019 rst_in is the only reset; it resets rst path behaviour per REQ-010..REQ-014, not the synchronizer chain or rst_events.
REQ-020 Power-up (initial register values): s[] all 1, rst = 1, rst_n = 0, low_cnt = 0, rst_done = 0, rst_events = 0.
REQ-021 With rst_in held low from power-up, rst SHALL release SYNC_STAGES+RELEASE_CYCLES-1 edges after the first edge, with rst_done pulsing once.
REQ-022 rst_events SHALL not count the power-up asserted state as an event.

Verification
REQ-023 Defaults, rst_in held 1 for 11 cycles then 0 at edge k -> rst stays 1 through edge k+8, rst = 0 after edge k+9, rst_done = 1 for next cycle only.
REQ-024 rst_in = 0 steady, single-cycle rst_in = 1 sampled at edge k -> rst = 1 after edge k+2, held 8 cycles minimum, rst_events +1.
REQ-025 During release count (5 low samples taken) rst_in high for one cycle -> count restarts, rst never drops, rst_events unchanged.
REQ-026 Alternating rst_in windows high 12/low 12/high 13/low 13/... cycles -> rst high/low windows shifted per REQ-010/REQ-012, rst_n always ~rst, rst_events increments once per high window.
REQ-027 300 rst_in pulses separated by 20 low cycles -> rst_events saturates at 255 and holds.
REQ-028 Power-up with rst_in = 0 -> rst = 1 initially, release after edge 9 (defaults), rst_events = 0.
